multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequential successor to the single-cycle control decoder: a Moore-style finite state machine (FSM) that sequences the multi-cycle MIPS datapath through fetch, decode, execute, memory and write-back steps. It supports the same instruction subset (ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, J, NOP) and adds three things: a memory ready handshake with stalls, illegal-opcode trapping, and a retired-instruction counter. It sits between the instruction register (IR) and the shared-memory datapath, replacing the combinational decoder in the multi-cycle core.

## Interface
- ALU_CNTRL_W, 4, width of the ALU control code
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- op_in  in  6  IR[31:26]; valid from DECODE onward
- func_in  in  6  IR[5:0]; valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond, ir_write  out  1  PC / IR enables
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU output
- mem_read, mem_write  out  1  memory request strobes
- mem_to_reg, reg_dst, reg_write  out  1  register-file controls
- alu_src_a  out  1  ALU input A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU input B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALU output register, 10 = jump target
- alu_cntrl  out  ALU_CNTRL_W  ALU operation code
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- instr_count  out  CNT_W  count of retired instructions
- state_o  out  4  current state, for debug

## Operation
- States and transitions (all unconditional unless noted):
  - RESET → FETCH.
  - FETCH stays in FETCH until mem_ready=1, then → DECODE.
  - DECODE → MEM_ADDR for LW/SW, EXEC_R for an R-type with a legal funct, EXEC_I for ADDI, BRANCH for BEQ, JUMP for J, FETCH for NOP or illegal.
  - MEM_ADDR → MEM_RD for LW, MEM_WR for SW.
  - MEM_RD stays until mem_ready=1, then → MEM_WB. MEM_WB → FETCH.
  - MEM_WR stays until mem_ready=1, then → FETCH.
  - EXEC_R → RTYPE_WB → FETCH.
  - EXEC_I → ITYPE_WB → FETCH.
  - BRANCH → FETCH. JUMP → FETCH.
- NOP is op_in=0 and func_in=0. It produces no register or memory write and retires.
- Output asserts by state; every output not listed is 0:
  - RESET: all outputs 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_cntrl=ADD; ir_write=1 and pc_write=1 only while mem_ready=1.
  - DECODE: alu_src_b=11, alu_cntrl=ADD.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_cntrl=ADD.
  - MEM_RD: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1.
  - MEM_WR: mem_write=1, i_or_d=1.
  - EXEC_R: alu_src_a=1, alu_cntrl from funct.
  - RTYPE_WB: reg_write=1, reg_dst=1.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_cntrl=ADD.
  - ITYPE_WB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_cntrl=SUB, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- Funct-to-ALU code mapping: ADD 100000 → 0000, SUB 100010 → 0001, AND 100100 → 0010, SLT 101010 → 0100, OR 100101 → 0101. Any other funct with op_in=0 (excluding NOP) is illegal.
- Legal opcodes are 000000, 001000, 100011, 101011, 000100 and 000010. Anything else pulses illegal_op in DECODE, and the FSM returns to FETCH without retiring.
- instr_count increments by 1 on entry to FETCH from any state except RESET, excluding the illegal path. It wraps modulo 2^CNT_W.

## Timing
- rst=1 at a clock edge forces state=RESET and instr_count=0, overriding everything, including mid-instruction and mid-stall. There is no pending memory request after reset.
- All outputs are decoded from the state register except ir_write and pc_write in FETCH, which are qualified combinationally by mem_ready.
- Latency with zero-wait memory (mem_ready held at 1), counted from FETCH to the next FETCH:
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - NOP, illegal: 2 cycles.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle. mem_read or mem_write stays high throughout the stall.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- The first FETCH after reset is on cycle 2 (RESET occupies cycle 1).

## Structure
- Shared package `mips_ctrl_pkg`:
  - opcode and funct constants;
  - ALU control codes;
  - state enum (4-bit);
  - alu_src_b and pc_source encodings.
- Natural sub-module: `alu_ctrl_decode` (combinational, funct to alu_cntrl plus legal flag), reused by the pipelined core.

## Test plan
- Reset then ADD: rst for 2 cycles, op_in=000000, func_in=100000, mem_ready=1 → states RESET, FETCH, DECODE, EXEC_R, RTYPE_WB, FETCH; reg_write=1 and reg_dst=1 only in RTYPE_WB; instr_count=1.
- LW with 3 wait cycles: mem_ready=0 for 3 cycles in MEM_RD → mem_read=1 and i_or_d=1 held 4 cycles; MEM_WB asserts reg_write=1 and mem_to_reg=1; total 8 cycles.
- BEQ then J: BEQ → BRANCH asserts pc_write_cond=1, pc_source=01, alu_cntrl=0001; J → JUMP asserts pc_write=1, pc_source=10; 3 cycles each.
- Illegal op: op_in=111111 → illegal_op=1 for exactly 1 cycle in DECODE, next state FETCH, instr_count unchanged; an R-type with func_in=000111 behaves the same.
- NOP then SLT: NOP retires in 2 cycles with no write asserted; SLT (func_in=101010) produces alu_cntrl=0100 in EXEC_R.
- rst asserted in MEM_WR with mem_ready=0 → next cycle state=RESET, mem_write=0, instr_count=0; counter wrap checked with CNT_W=4 after 16 retirements → instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control path: opcodes, functs, ALU codes,
// multi-cycle FSM states and datapath mux encodings.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0]); an all-zero R-type word is a NOP
    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    // ALU input B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Multi-cycle controller states
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_EXEC_I   = 4'd9,
        S_ITYPE_WB = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_is_legal = 1'b1;
            default:                                       op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle. The controller side (master) consumes the
// IR fields and memory ready, and drives every datapath enable and select.
// mem_ready is a level: it means the memory access presented this cycle
// completes this cycle; the request strobe stays high until it is seen.
interface multicycle_control_if #(
    parameter int ALU_CNTRL_W = 4,
    parameter int CNT_W       = 32
);
    logic [5:0]             op_in;
    logic [5:0]             func_in;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic                   ir_write;
    logic                   i_or_d;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   reg_dst;
    logic                   reg_write;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             pc_source;
    logic [ALU_CNTRL_W-1:0] alu_cntrl;
    logic                   illegal_op;
    logic [CNT_W-1:0]       instr_count;

    modport master (
        input  op_in, func_in, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_cntrl, illegal_op, instr_count
    );

    modport slave (
        output op_in, func_in, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_cntrl, illegal_op, instr_count
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational funct-to-ALU-code decoder with a legality flag. Shared with
// the pipelined core, so it knows nothing about opcodes or NOPs.
module alu_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [3:0] alu_cntrl_o,
    output logic       legal_o
);

    // Map each supported funct to its ALU code; flag everything else
    always_comb begin
        alu_cntrl_o = ALU_ADD;
        legal_o     = 1'b1;
        case (func_i)
            FN_ADD:  alu_cntrl_o = ALU_ADD;
            FN_SUB:  alu_cntrl_o = ALU_SUB;
            FN_AND:  alu_cntrl_o = ALU_AND;
            FN_OR:   alu_cntrl_o = ALU_OR;
            FN_SLT:  alu_cntrl_o = ALU_SLT;
            default: legal_o     = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle MIPS datapath. Steps each
// instruction through fetch/decode/execute/memory/write-back, stalls on
// memory ready, traps unsupported encodings and counts retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CNTRL_W = 4,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus,
    output logic [3:0]           state_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic [3:0] funct_alu;
    logic       funct_legal;
    logic       is_nop;
    logic       instr_illegal;

    logic       pc_write, pc_write_cond, ir_write, i_or_d;
    logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_code;

    alu_ctrl_decode u_alu_dec (
        .func_i      (bus.func_in),
        .alu_cntrl_o (funct_alu),
        .legal_o     (funct_legal)
    );

    // An all-zero R-type word is a NOP; any other unknown funct is a trap
    assign is_nop        = (bus.op_in == OP_RTYPE) && (bus.func_in == FN_NOP);
    assign instr_illegal = !op_is_legal(bus.op_in) ||
                           ((bus.op_in == OP_RTYPE) && !is_nop && !funct_legal);

    // State and retired-instruction counter; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, retire strobe and state-decoded datapath controls
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_code      = ALU_ADD;
        illegal_op    = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_code  = ALU_ADD;
                // IR load and PC+4 only on the cycle the fetch completes
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                alu_code   = ALU_ADD;
                illegal_op = instr_illegal;
                case (bus.op_in)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (is_nop) begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end else if (funct_legal) begin
                            state_d = S_EXEC_R;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_code  = ALU_ADD;
                state_d   = (bus.op_in == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_code  = funct_alu;
                state_d   = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_code  = ALU_ADD;
                state_d   = S_ITYPE_WB;
            end
            S_ITYPE_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_code      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.ir_write      = ir_write;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.pc_source     = pc_source;
    assign bus.alu_cntrl     = ALU_CNTRL_W'(alu_code);
    assign bus.illegal_op    = illegal_op;
    assign bus.instr_count   = cnt_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle step sequence, and a compare
// process checks every cycle. A second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef enum int {K_NOP, K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    localparam int EW = 4 + 19 + 32 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_in = '0;
    logic [5:0] func_in = '0;
    logic       mem_ready = 1'b0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_func = '0;
    logic [3:0] state32, state4;
    logic [18:0] ctrl32, ctrl4;

    logic [31:0]   model_cnt = '0;
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Clock
    always #5 clk = ~clk;

    multicycle_control_if #(.ALU_CNTRL_W(4), .CNT_W(32)) bus32 ();
    multicycle_control_if #(.ALU_CNTRL_W(4), .CNT_W(4))  bus4 ();

    assign bus32.op_in     = op_in;
    assign bus32.func_in   = func_in;
    assign bus32.mem_ready = mem_ready;
    assign bus4.op_in      = op_in;
    assign bus4.func_in    = func_in;
    assign bus4.mem_ready  = mem_ready;

    multicycle_control #(.ALU_CNTRL_W(4), .CNT_W(32)) u_dut32 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus32.master),
        .state_o (state32)
    );

    multicycle_control #(.ALU_CNTRL_W(4), .CNT_W(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus4.master),
        .state_o (state4)
    );

    assign ctrl32 = {bus32.pc_write, bus32.pc_write_cond, bus32.ir_write, bus32.i_or_d,
                     bus32.mem_read, bus32.mem_write, bus32.mem_to_reg, bus32.reg_dst,
                     bus32.reg_write, bus32.alu_src_a, bus32.alu_src_b, bus32.pc_source,
                     bus32.alu_cntrl, bus32.illegal_op};
    assign ctrl4  = {bus4.pc_write, bus4.pc_write_cond, bus4.ir_write, bus4.i_or_d,
                     bus4.mem_read, bus4.mem_write, bus4.mem_to_reg, bus4.reg_dst,
                     bus4.reg_write, bus4.alu_src_a, bus4.alu_src_b, bus4.pc_source,
                     bus4.alu_cntrl, bus4.illegal_op};

    // Instruction class from the supported-subset rules
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b000000) return K_NOP;
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return K_R;
                    default: return K_ILL;
                endcase
            end
            6'b001000: return K_ADDI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0001;
            6'b100100: return 4'b0010;
            6'b101010: return 4'b0100;
            6'b100101: return 4'b0101;
            default:   return 4'b0000;
        endcase
    endfunction

    // Expected control word for one step of an instruction
    function automatic logic [18:0] exp_ctrl(input state_t st, input logic rdy,
                                             input logic [3:0] alu_r, input logic ill);
        logic pcw, pcwc, irw, iord, mr, mw, m2r, rdst, rw, sa, il;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        {pcw, pcwc, irw, iord, mr, mw, m2r, rdst, rw, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; alu = 4'b0000;
        case (st)
            S_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sb = 2'b11; il = ill; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            S_MEM_RD:   begin mr = 1; iord = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mw = 1; iord = 1; end
            S_EXEC_R:   begin sa = 1; alu = alu_r; end
            S_RTYPE_WB: begin rw = 1; rdst = 1; end
            S_EXEC_I:   begin sa = 1; sb = 2'b10; end
            S_ITYPE_WB: begin rw = 1; end
            S_BRANCH:   begin sa = 1; alu = 4'b0001; pcwc = 1; ps = 2'b01; end
            S_JUMP:     begin pcw = 1; ps = 2'b10; end
            default:    ;
        endcase
        return {pcw, pcwc, irw, iord, mr, mw, m2r, rdst, rw, sa, sb, ps, alu, il};
    endfunction

    // Driver: one clock of stimulus plus the expectation for that cycle
    task automatic do_cycle(input state_t st, input logic rdy, input logic r,
                            input logic [3:0] alu_r, input logic ill);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        op_in     = cur_op;
        func_in   = cur_func;
        exp_q.push_back({4'(st), exp_ctrl(st, rdy, alu_r, ill), model_cnt, model_cnt[3:0]});
    endtask

    // Driver: one whole instruction with optional fetch and memory waits
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fetch_waits, input int mem_waits);
        kind_t      k;
        logic [3:0] a;
        cur_op   = op;
        cur_func = fn;
        k = classify(op, fn);
        a = alu_of(fn);
        for (int i = 0; i < fetch_waits; i++) do_cycle(S_FETCH, 1'b0, 1'b0, a, 1'b0);
        do_cycle(S_FETCH, 1'b1, 1'b0, a, 1'b0);
        do_cycle(S_DECODE, 1'b0, 1'b0, a, k == K_ILL);
        case (k)
            K_LW: begin
                do_cycle(S_MEM_ADDR, 1'b0, 1'b0, a, 1'b0);
                for (int i = 0; i < mem_waits; i++) do_cycle(S_MEM_RD, 1'b0, 1'b0, a, 1'b0);
                do_cycle(S_MEM_RD, 1'b1, 1'b0, a, 1'b0);
                do_cycle(S_MEM_WB, 1'b0, 1'b0, a, 1'b0);
            end
            K_SW: begin
                do_cycle(S_MEM_ADDR, 1'b0, 1'b0, a, 1'b0);
                for (int i = 0; i < mem_waits; i++) do_cycle(S_MEM_WR, 1'b0, 1'b0, a, 1'b0);
                do_cycle(S_MEM_WR, 1'b1, 1'b0, a, 1'b0);
            end
            K_R: begin
                do_cycle(S_EXEC_R, 1'b0, 1'b0, a, 1'b0);
                do_cycle(S_RTYPE_WB, 1'b0, 1'b0, a, 1'b0);
            end
            K_ADDI: begin
                do_cycle(S_EXEC_I, 1'b0, 1'b0, a, 1'b0);
                do_cycle(S_ITYPE_WB, 1'b0, 1'b0, a, 1'b0);
            end
            K_BEQ: do_cycle(S_BRANCH, 1'b0, 1'b0, a, 1'b0);
            K_J:   do_cycle(S_JUMP, 1'b0, 1'b0, a, 1'b0);
            default: ;
        endcase
        if (k != K_ILL) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One fetch stall cycle, then pin both counters against literals
    task automatic stall_and_pin(input string name, input logic [31:0] want32,
                                 input logic [31:0] want4);
        do_cycle(S_FETCH, 1'b0, 1'b0, 4'b0000, 1'b0);
        #3;
        check_lit({name, "_cnt32"}, bus32.instr_count, want32);
        check_lit({name, "_cnt4"}, 32'(bus4.instr_count), want4);
    endtask

    // Scoreboard: compare both instances against the expected queue
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({state32, ctrl32, bus32.instr_count, bus4.instr_count} !== e) begin
                errors++;
                $display("FAIL cycle32 t=%0t: got st=%0d ctrl=%05h cnt=%0h cnt4=%0h want st=%0d ctrl=%05h cnt=%0h cnt4=%0h",
                         $time, state32, ctrl32, bus32.instr_count, bus4.instr_count,
                         e[58:55], e[54:36], e[35:4], e[3:0]);
            end
            checks++;
            if ({state4, ctrl4} !== e[58:36]) begin
                errors++;
                $display("FAIL cycle4 t=%0t: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                         $time, state4, ctrl4, e[58:55], e[54:36]);
            end
        end
    end

    // Directed sequence
    initial begin
        // Reset for two cycles, then RESET for one more, then ADD
        do_cycle(S_RESET, 1'b0, 1'b1, 4'b0000, 1'b0);
        do_cycle(S_RESET, 1'b0, 1'b1, 4'b0000, 1'b0);
        do_cycle(S_RESET, 1'b0, 1'b0, 4'b0000, 1'b0);
        run_instr(6'b000000, 6'b100000, 0, 0);
        stall_and_pin("after_add", 32'd1, 32'd1);

        // LW with three memory waits, then BEQ and J
        run_instr(6'b100011, 6'b000000, 0, 3);
        run_instr(6'b000100, 6'b000000, 0, 0);
        run_instr(6'b000010, 6'b000000, 0, 0);
        stall_and_pin("after_lw_beq_j", 32'd4, 32'd4);

        // Illegal opcode and illegal funct: no retirement
        run_instr(6'b111111, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b000111, 0, 0);
        stall_and_pin("after_illegal", 32'd4, 32'd4);

        // NOP, SLT, SW with waits, ADDI, OR, AND, SUB
        run_instr(6'b000000, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b101010, 0, 0);
        run_instr(6'b101011, 6'b000000, 2, 1);
        run_instr(6'b001000, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b100101, 1, 0);
        run_instr(6'b000000, 6'b100100, 0, 0);
        run_instr(6'b000000, 6'b100010, 0, 0);
        stall_and_pin("after_mix", 32'd11, 32'd11);

        // Reset while stalled in MEM_WR
        cur_op   = 6'b101011;
        cur_func = 6'b000000;
        do_cycle(S_FETCH, 1'b1, 1'b0, 4'b0000, 1'b0);
        do_cycle(S_DECODE, 1'b0, 1'b0, 4'b0000, 1'b0);
        do_cycle(S_MEM_ADDR, 1'b0, 1'b0, 4'b0000, 1'b0);
        do_cycle(S_MEM_WR, 1'b0, 1'b0, 4'b0000, 1'b0);
        do_cycle(S_MEM_WR, 1'b0, 1'b1, 4'b0000, 1'b0);
        model_cnt = '0;
        do_cycle(S_RESET, 1'b0, 1'b0, 4'b0000, 1'b0);
        #3;
        check_lit("rst_state", 32'(state32), 32'd0);
        check_lit("rst_mem_write", 32'(bus32.mem_write), 32'd0);
        check_lit("rst_cnt32", bus32.instr_count, 32'd0);

        // Sixteen retirements wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0:       run_instr(6'b000000, 6'b100000, 0, 0);
                1:       run_instr(6'b000000, 6'b000000, 0, 0);
                2:       run_instr(6'b000010, 6'b000000, 0, 0);
                default: run_instr(6'b000100, 6'b000000, 0, 0);
            endcase
        end
        stall_and_pin("after_wrap", 32'd16, 32'd0);

        @(negedge clk);
        #1;
        check_lit("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
